// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory access controller.
// Turns a load/store sitting in EX/MEM into one req/ack bus transfer and
// stalls the pipeline until it completes or times out. ReadDataM is the raw
// aligned word; lane extraction and sign extension happen in WB.
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// word/half accesses are refused in IDLE and pulse AlignErrM. When it is
// undefined, AlignErrM is tied low and every access proceeds.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 16,  // REQ cycles before bus error, 0 = never
  parameter int unsigned CNT_W   = 5    // 2**CNT_W must exceed TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [1:0]  StoreTypeM,
  input  logic [2:0]  LoadTypeM,
  input  logic        FlushM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        BusErrM,
  output logic        AlignErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_buserr;

  logic        w_acc;
  logic        w_misalign;
  logic        w_start;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // A store wins over a load when both are flagged; a flush kills either.
  assign w_acc = (MemReadM | MemWriteM) & ~FlushM;

  // Expiry only counts when no ack arrived in the same cycle.
  assign w_timeout = (TIMEOUT != 0) && (r_state == S_REQ) && !dmem_ack &&
                     (r_cnt == LP_CNT_LAST);

  // Lane selection for byte enables and replicated store data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (MemWriteM) begin
      case (StoreTypeM)
        2'd1: begin
          w_be    = 4'b0001 << ALUOutM[1:0];
          w_wdata = {4{WriteDataM[7:0]}};
        end
        2'd2: begin
          w_be    = ALUOutM[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{WriteDataM[15:0]}};
        end
        default: w_wdata = WriteDataM;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Flags word accesses off a word boundary and halves off a half boundary.
  always_comb begin
    w_misalign = 1'b0;
    if (MemWriteM) begin
      case (StoreTypeM)
        2'd1:    w_misalign = 1'b0;
        2'd2:    w_misalign = ALUOutM[0];
        default: w_misalign = |ALUOutM[1:0];
      endcase
    end else begin
      case (LoadTypeM)
        3'd1, 3'd2: w_misalign = 1'b0;
        3'd3, 3'd4: w_misalign = ALUOutM[0];
        default:    w_misalign = |ALUOutM[1:0];
      endcase
    end
  end
`else
  // Load width only matters to the alignment trap; WB does the extraction.
  logic w_unused_load_type;
  assign w_unused_load_type = ^LoadTypeM;
  assign w_misalign         = 1'b0;
`endif

  // Next-state and the two combinational outputs (StallM, AlignErrM).
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    StallM       = 1'b0;
    AlignErrM    = 1'b0;
    case (r_state)
      S_IDLE: begin
        AlignErrM = w_acc & w_misalign;
        w_start   = w_acc & ~w_misalign;
        StallM    = w_start;
        if (w_start) w_next_state = S_REQ;
      end
      S_REQ: begin
        StallM = 1'b1;
        if (dmem_ack || w_timeout) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Bus outputs, timeout counter, read-data capture and bus-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'h0;
      r_be     <= 4'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_buserr <= 1'b0;
    end else begin
      r_buserr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= MemWriteM;
            r_addr  <= {ALUOutM[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
          end
        end
        S_REQ: begin
          if (dmem_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_rdata <= dmem_rdata;
          end else if (w_timeout) begin
            r_req    <= 1'b0;
            r_buserr <= 1'b1;
            r_rdata  <= 32'h0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;
  assign ReadDataM  = r_rdata;
  assign BusErrM    = r_buserr;

endmodule
